// File: rtl/avalon_bus_burst_rw_verify.sv
// Avalon-MM memory test master for the DDR controller port.
// A button press fills NUM_WORDS words with a selectable pattern in
// BURST_LEN-beat write bursts, reads the same region back burst by burst and
// compares every beat. The result is reported as pass/fail, a saturating
// error count and the address of the first mismatch.
//
// Ports:
//   iCLK, iRST_n        clock, async active-low reset
//   iBUTTON             start button (active-low, asynchronous)
//   iMODE               pattern: 0=addr, 1=~addr, 2=LFSR, 3=walking one
//   local_init_done     memory calibration done; losing it aborts the run
//   avl_*               Avalon-MM burst master towards the memory controller
//   drv_status_*        complete / pass / fail, valid in DONE
//   err_count           mismatching beats (saturating)
//   first_err_addr      word address of the first mismatch
//   c_state             current state code for debug LEDs
module avalon_bus_burst_rw_verify #(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 2073600,
  parameter int BURST_LEN = 8,
  parameter int BCNT_W    = 7,
  parameter int TIMEOUT   = 1023
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iBUTTON,
  input  logic [1:0]        iMODE,
  input  logic              local_init_done,
  input  logic              avl_waitrequest_n,
  output logic [ADDR_W-1:0] avl_address,
  output logic [BCNT_W-1:0] avl_burstcount,
  output logic              avl_burstbegin,
  output logic              avl_write,
  output logic [DATA_W-1:0] avl_writedata,
  output logic              avl_read,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              avl_readdatavalid,
  output logic              drv_status_test_complete,
  output logic              drv_status_pass,
  output logic              drv_status_fail,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [3:0]        c_state
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_WORDS - BURST_LEN);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
  localparam logic [BCNT_W-1:0] LAST_BEAT  = BCNT_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX    = TMO_W'(TIMEOUT);
  localparam logic [31:0]       LFSR_SEED  = 32'hACE1_0001;
  // Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0]       LFSR_TAPS  = 32'h8020_0003;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_BEAT = 4'd1,
    S_WR_NEXT = 4'd2,
    S_RD_CMD  = 4'd3,
    S_RD_DATA = 4'd4,
    S_RD_NEXT = 4'd5,
    S_DONE    = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        pre_button_q, pre_button_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BCNT_W-1:0] beat_q, beat_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic              bb_q, bb_d;

  logic              trigger;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] cur_pat;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Pattern word for word address a; the LFSR word is replicated to DATA_W.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [31:0] l);
    logic [DATA_W-1:0] ax, lx, oh;
    logic [ADDR_W-1:0] sh;
    sh = a % ADDR_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      ax[i] = (i < ADDR_W) ? a[i % ADDR_W] : 1'b0;
      lx[i] = l[i % 32];
      oh[i] = (sh == ADDR_W'(i));
    end
    case (m)
      2'd0:    return ax;
      2'd1:    return ~ax;
      2'd2:    return lx;
      default: return oh;
    endcase
  endfunction

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= S_IDLE;
      pre_button_q <= 2'b11;
      mode_q       <= 2'd0;
      addr_q       <= '0;
      beat_q       <= '0;
      lfsr_q       <= LFSR_SEED;
      err_q        <= '0;
      first_err_q  <= '0;
      tmo_q        <= '0;
      tmo_flag_q   <= 1'b0;
      bb_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_button_q <= pre_button_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      lfsr_q       <= lfsr_d;
      err_q        <= err_d;
      first_err_q  <= first_err_d;
      tmo_q        <= tmo_d;
      tmo_flag_q   <= tmo_flag_d;
      bb_q         <= bb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pre_button_d = {pre_button_q[0], iBUTTON};
    mode_d       = mode_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    lfsr_d       = lfsr_q;
    err_d        = err_q;
    first_err_d  = first_err_q;
    tmo_d        = tmo_q;
    tmo_flag_d   = tmo_flag_q;
    // falling edge of the synchronised button
    trigger      = pre_button_q[1] & ~pre_button_q[0];
    beat_addr    = addr_q + ADDR_W'(beat_q);
    cur_pat      = pattern(mode_q, beat_addr, lfsr_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (trigger && local_init_done) begin
          state_d     = S_WR_BEAT;
          mode_d      = iMODE;
          addr_d      = '0;
          beat_d      = '0;
          lfsr_d      = LFSR_SEED;
          err_d       = '0;
          first_err_d = '0;
          tmo_d       = '0;
          tmo_flag_d  = 1'b0;
        end
      end
      S_WR_BEAT: begin
        if (avl_waitrequest_n) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_WR_NEXT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_WR_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          // read pass regenerates the same sequence from word 0
          addr_d  = '0;
          lfsr_d  = LFSR_SEED;
          state_d = S_RD_CMD;
        end else begin
          addr_d  = addr_q + BURST_STEP;
          state_d = S_WR_BEAT;
        end
      end
      S_RD_CMD: begin
        tmo_d = '0;
        if (avl_waitrequest_n) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (avl_readdatavalid) begin
          tmo_d  = '0;
          lfsr_d = lfsr_step(lfsr_q);
          if (avl_readdata != cur_pat) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            // err_q never returns to zero within a run, so it marks the first error
            if (err_q == 16'd0) first_err_d = beat_addr;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_RD_NEXT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (tmo_q == TMO_MAX) begin
          tmo_flag_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RD_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + BURST_STEP;
          state_d = S_RD_CMD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // losing calibration abandons the run without reporting a result
    if (!local_init_done && state_q != S_IDLE && state_q != S_DONE) state_d = S_IDLE;

    // burstbegin marks the first cycle a new command is presented
    bb_d = (state_d != state_q) && (state_d == S_WR_BEAT || state_d == S_RD_CMD);
  end

  // Requests are also gated by local_init_done so they drop the same cycle.
  assign avl_write      = (state_q == S_WR_BEAT) & local_init_done;
  assign avl_read       = (state_q == S_RD_CMD) & local_init_done;
  assign avl_burstbegin = bb_q & local_init_done;
  assign avl_writedata  = avl_write ? cur_pat : '0;
  assign avl_address    = addr_q;
  assign avl_burstcount = BCNT_W'(BURST_LEN);

  assign drv_status_test_complete = (state_q == S_DONE);
  assign drv_status_pass = (state_q == S_DONE) && (err_q == 16'd0) && !tmo_flag_q;
  assign drv_status_fail = (state_q == S_DONE) && ((err_q != 16'd0) || tmo_flag_q);
  assign err_count       = err_q;
  assign first_err_addr  = first_err_q;
  assign c_state         = state_q;

endmodule

// File: tb/tb_avalon_bus_burst_rw_verify.sv
// Bench for avalon_bus_burst_rw_verify: 32 words, 4-beat bursts, short timeout.
// A memory model stores accepted writes and returns read bursts, optionally
// corrupting or withholding data; a monitor compares every command cycle with
// an expected word table built from the pattern rules.
module tb_avalon_bus_burst_rw_verify;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int NW     = 32;
  localparam int BL     = 4;
  localparam int BCNT_W = 7;
  localparam int TMO    = 40;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic              iCLK = 1'b0;
  logic              iRST_n, iBUTTON, local_init_done;
  logic [1:0]        iMODE;
  logic              avl_waitrequest_n, avl_readdatavalid;
  logic [DATA_W-1:0] avl_readdata, avl_writedata;
  logic [ADDR_W-1:0] avl_address, first_err_addr;
  logic [BCNT_W-1:0] avl_burstcount;
  logic              avl_burstbegin, avl_write, avl_read;
  logic              drv_status_test_complete, drv_status_pass, drv_status_fail;
  logic [15:0]       err_count;
  logic [3:0]        c_state;

  always #5 iCLK = ~iCLK;

  avalon_bus_burst_rw_verify #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NW), .BURST_LEN(BL),
    .BCNT_W(BCNT_W), .TIMEOUT(TMO)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iBUTTON(iBUTTON), .iMODE(iMODE),
    .local_init_done(local_init_done), .avl_waitrequest_n(avl_waitrequest_n),
    .avl_address(avl_address), .avl_burstcount(avl_burstcount),
    .avl_burstbegin(avl_burstbegin), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_read(avl_read),
    .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
    .drv_status_test_complete(drv_status_test_complete),
    .drv_status_pass(drv_status_pass), .drv_status_fail(drv_status_fail),
    .err_count(err_count), .first_err_addr(first_err_addr), .c_state(c_state)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  logic [31:0] exp_data [NW];
  logic [31:0] mem      [NW];
  logic [31:0] cap      [NW];
  bit          corrupt  [NW];
  logic [31:0] rd_q [$];
  int wr_idx, rd_cmds, bb_wr, bb_rd, tmo_cycles, drop_at;
  bit bb_due, dropped, stall_en, stray_en;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    logic [31:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [31:0] model_pat(input int mode, input int w, input logic [31:0] l);
    case (mode)
      0:       return 32'(w);
      1:       return ~32'(w);
      2:       return l;
      default: return 32'h1 << (w % 32);
    endcase
  endfunction

  task automatic build_model(input int mode);
    logic [31:0] l;
    l = SEED;
    for (int w = 0; w < NW; w++) begin
      exp_data[w] = model_pat(mode, w, l);
      l = lfsr_next(l);
    end
  endtask

  // ---------------- slave + monitor ----------------
  initial begin
    avl_waitrequest_n = 1'b1;
    avl_readdatavalid = 1'b0;
    avl_readdata      = '0;
    forever begin
      @(posedge iCLK); #1;
      avl_waitrequest_n = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_q.size() > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
        avl_readdatavalid = 1'b1;
        avl_readdata      = rd_q.pop_front();
      end else if (stray_en && wr_idx < NW && rd_q.size() == 0 && $urandom_range(0, 1) == 1) begin
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'hDEAD_BEEF;
      end else begin
        avl_readdatavalid = 1'b0;
        avl_readdata      = '0;
      end
      @(negedge iCLK);
      if (avl_write) begin
        chk("wr_burstbegin", avl_burstbegin, bb_due);
        chk("wr_burstcount", avl_burstcount, BL);
        chk("wr_in_range", wr_idx < NW, 1);
        if (avl_burstbegin) bb_wr++;
        bb_due = 0;
        chk("wr_addr", avl_address, (wr_idx / BL) * BL);
        if (wr_idx < NW) begin
          chk("wr_data", avl_writedata, exp_data[wr_idx]);
          if (avl_waitrequest_n) begin
            mem[(int'(avl_address) + wr_idx % BL) % NW] = avl_writedata;
            cap[wr_idx] = avl_writedata;
            wr_idx++;
            if (wr_idx % BL == 0) bb_due = 1;
          end
        end
      end else if (avl_read) begin
        chk("rd_burstbegin", avl_burstbegin, bb_due);
        chk("rd_burstcount", avl_burstcount, BL);
        chk("rd_after_writes", wr_idx, NW);
        chk("rd_addr", avl_address, rd_cmds * BL);
        if (avl_burstbegin) bb_rd++;
        bb_due = 0;
        if (avl_waitrequest_n) begin
          rd_cmds++;
          bb_due = 1;
          if (drop_at != 0 && rd_cmds >= drop_at) dropped = 1;
          else
            for (int k = 0; k < BL; k++) begin
              int a;
              a = (int'(avl_address) + k) % NW;
              rd_q.push_back(mem[a] ^ {31'd0, corrupt[a]});
            end
        end
      end else begin
        chk("idle_burstbegin", avl_burstbegin, 0);
      end
      if (dropped && c_state == 4'd4) tmo_cycles++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input bit expect_start);
    int n;
    @(posedge iCLK); #1 iBUTTON = 1'b0;
    if (expect_start) begin
      n = 0;
      while (c_state !== 4'd1 && n < 10) begin @(negedge iCLK); n++; end
      chk("started", c_state, 1);
    end else begin
      repeat (3) @(negedge iCLK);
    end
    @(posedge iCLK); #1 iBUTTON = 1'b1;
  endtask

  task automatic start_run(input int mode, input bit stall, input bit stray, input int drop);
    @(posedge iCLK); #2;
    iMODE = 2'(mode);
    stall_en = stall; stray_en = stray; drop_at = drop;
    build_model(mode);
    wr_idx = 0; rd_cmds = 0; bb_wr = 0; bb_rd = 0; bb_due = 1;
    dropped = 0; tmo_cycles = 0;
    rd_q.delete();
    press(1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (c_state !== 4'd9 && n < 3000) begin @(negedge iCLK); n++; end
    chk("done_reached", c_state, 9);
  endtask

  task automatic end_checks(input bit exp_pass, input int exp_rd);
    int ce, cf;
    ce = 0; cf = 0;
    for (int w = 0; w < NW; w++)
      if (corrupt[w] && (w / BL) < exp_rd && drop_at == 0) begin
        if (ce == 0) cf = w;
        ce++;
      end
    chk("complete", drv_status_test_complete, 1);
    chk("pass", drv_status_pass, exp_pass);
    chk("fail", drv_status_fail, !exp_pass);
    chk("err_count", err_count, ce);
    chk("first_err_addr", first_err_addr, cf);
    chk("words_written", wr_idx, NW);
    chk("wr_bursts", bb_wr, NW / BL);
    chk("rd_cmds", rd_cmds, exp_rd);
    chk("rd_bursts", bb_rd, exp_rd);
  endtask

  task automatic wait_writing(input int min_idx);
    int n;
    n = 0;
    do begin @(negedge iCLK); n++; end
    while (!(wr_idx >= min_idx && avl_write === 1'b1) && n < 500);
    chk("reached_write", avl_write, 1);
  endtask

  // ---------------- main ----------------
  initial begin
    iRST_n = 1'b0; iBUTTON = 1'b1; local_init_done = 1'b0; iMODE = 2'd0;
    stall_en = 0; stray_en = 0; drop_at = 0; dropped = 0; bb_due = 1;
    wr_idx = 0; rd_cmds = 0; bb_wr = 0; bb_rd = 0; tmo_cycles = 0;
    for (int w = 0; w < NW; w++) begin corrupt[w] = 0; mem[w] = '0; cap[w] = '0; end
    #12;
    chk("rst_write", avl_write, 0);
    chk("rst_read", avl_read, 0);
    chk("rst_burstbegin", avl_burstbegin, 0);
    chk("rst_writedata", avl_writedata, 0);
    chk("rst_address", avl_address, 0);
    chk("rst_burstcount", avl_burstcount, BL);
    chk("rst_status", {drv_status_test_complete, drv_status_pass, drv_status_fail}, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first_err", first_err_addr, 0);
    chk("rst_state", c_state, 0);
    @(posedge iCLK); #1 iRST_n = 1'b1; local_init_done = 1'b1;
    repeat (3) @(posedge iCLK);

    // model pins (hand-computed)
    build_model(2); chk("pin_lfsr_w1", exp_data[1], 32'hD650_8003);
    build_model(3); chk("pin_walk_w33", model_pat(3, 33, SEED), 32'h0000_0002);
    build_model(1); chk("pin_inv_w5", exp_data[5], 32'hFFFF_FFFA);

    // ideal memory, mode 0
    start_run(0, 0, 0, 0); wait_done(); end_checks(1, NW / BL);
    chk("lit_w31", cap[31], 32'd31);
    chk("lit_state_done", c_state, 9);

    // random stalls plus stray readdatavalid during writes
    start_run(0, 1, 1, 0); wait_done(); end_checks(1, NW / BL);

    // corrupted words 5 and 17
    corrupt[5] = 1; corrupt[17] = 1;
    start_run(0, 0, 0, 0); wait_done(); end_checks(0, NW / BL);
    chk("lit_err2", err_count, 2);
    chk("lit_first5", first_err_addr, 5);
    corrupt[5] = 0; corrupt[17] = 0;

    // rerun from DONE clears the counters
    start_run(0, 0, 0, 0); wait_done(); end_checks(1, NW / BL);

    // data withheld from the third read command on
    start_run(0, 0, 0, 3); wait_done(); end_checks(0, 3);
    chk("tmo_cycles", tmo_cycles, TMO + 1);

    // LFSR and walking-one patterns
    start_run(2, 1, 0, 0); wait_done(); end_checks(1, NW / BL);
    chk("lit_lfsr_w1", cap[1], 32'hD650_8003);
    start_run(3, 0, 0, 0); wait_done(); end_checks(1, NW / BL);
    chk("lit_walk_w1", cap[1], 32'h0000_0002);

    // button press during the write phase is ignored
    start_run(0, 0, 0, 0); wait_writing(6); press(0); wait_done(); end_checks(1, NW / BL);

    // calibration lost mid-write
    start_run(0, 1, 0, 0); wait_writing(10);
    #1 local_init_done = 1'b0;
    #1 chk("abort_write_low", avl_write, 0);
    chk("abort_bb_low", avl_burstbegin, 0);
    @(posedge iCLK); @(negedge iCLK);
    chk("abort_idle", c_state, 0);
    chk("abort_status", {drv_status_test_complete, drv_status_pass, drv_status_fail}, 0);
    @(posedge iCLK); #1 local_init_done = 1'b1;
    start_run(1, 0, 0, 0); wait_done(); end_checks(1, NW / BL);

    // async reset in the middle of a burst
    start_run(0, 1, 0, 0); wait_writing(3);
    #2 iRST_n = 1'b0;
    #1 chk("arst_write", avl_write, 0);
    chk("arst_writedata", avl_writedata, 0);
    chk("arst_address", avl_address, 0);
    chk("arst_state", c_state, 0);
    chk("arst_burstbegin", avl_burstbegin, 0);
    @(posedge iCLK); #1 iRST_n = 1'b1;
    start_run(0, 0, 0, 0); wait_done(); end_checks(1, NW / BL);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
